// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer slice.
//   state_t      - sequencer states (ARMED is used only when
//                  FETCH_SEQUENCER_SINGLE_STEP_EN is defined)
//   WORD_W       - processor / ROM word width (9)
//   *_DEFAULT    - default parameter values for the top level
//   opcode_match - compares the opcode field IR[8:6] of a word
package fetch_pkg;

  localparam int WORD_W = 9;
  localparam int ADDR_W_DEFAULT = 5;
  localparam logic [2:0] OP_MVI_DEFAULT = 3'b001;
  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 9'h1FF;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH_I = 4'd1,
    LATCH_I = 4'd2,
    FETCH_M = 4'd3,
    LATCH_M = 4'd4,
    ISSUE   = 4'd5,
    EXEC    = 4'd6,
    HALTED  = 4'd7,
    ARMED   = 4'd8
  } state_t;

  function automatic logic opcode_match(input logic [WORD_W-1:0] word,
                                        input logic [2:0] op);
    return (word[WORD_W-1 -: 3] == op);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bus between the fetch sequencer, the ROM and the
// processor.
//   Start, Done, ROM_q        - into the sequencer
//   Step                      - into the sequencer, only when
//                               FETCH_SEQUENCER_SINGLE_STEP_EN is defined
//   ROM_addr, DIN, Run,
//   Halted, PC                - out of the sequencer
// Modports: slave = sequencer side, master = environment side.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              Start;
  logic              Done;
  logic [WORD_W-1:0] ROM_q;
  logic [ADDR_W-1:0] ROM_addr;
  logic [WORD_W-1:0] DIN;
  logic              Run;
  logic              Halted;
  logic [ADDR_W-1:0] PC;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  logic              Step;

  modport slave  (input  Start, Done, ROM_q, Step,
                  output ROM_addr, DIN, Run, Halted, PC);
  modport master (output Start, Done, ROM_q, Step,
                  input  ROM_addr, DIN, Run, Halted, PC);
`else
  modport slave  (input  Start, Done, ROM_q,
                  output ROM_addr, DIN, Run, Halted, PC);
  modport master (output Start, Done, ROM_q,
                  input  ROM_addr, DIN, Run, Halted, PC);
`endif

endinterface

// File: rtl/fetch_sequencer_counter.sv
// counter_N_bits: N-bit up counter with synchronous load, used as the PC.
//   clk, rst - clock, asynchronous active-high reset (clears to 0)
//   en       - increment by one (wraps modulo 2^N)
//   load     - load d; takes priority over en
//   d        - load value
//   q        - count value
module counter_N_bits #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_r;

  // Count register: load wins over increment, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {N{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else if (en) begin
      q_r <= q_r + N'(1'b1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch stage in front of the 9-bit processor.
// Walks the PC through a 32x9 synchronous ROM, latches each instruction
// (and the trailing immediate of an mvi), issues a one-cycle Run pulse and
// waits for Done before fetching the next word. HALT_WORD parks the
// sequencer in HALTED until Reset.
//   Clock, Reset - rising-edge clock, asynchronous active-high reset
//   bus (slave)  - Start/Done/ROM_q in; ROM_addr/DIN/Run/Halted/PC out
// Optional feature, macro FETCH_SEQUENCER_SINGLE_STEP_EN: adds bus.Step and
// the ARMED state; each instruction waits in ARMED for a Step rising edge.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [2:0]        OP_MVI    = OP_MVI_DEFAULT,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input logic              Clock,
  input logic              Reset,
  fetch_sequencer_if.slave bus
);

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  localparam state_t AFTER_LATCH = ARMED;
`else
  localparam state_t AFTER_LATCH = ISSUE;
`endif

  state_t            state_r;
  state_t            state_s;
  logic [WORD_W-1:0] ir_r;
  logic [WORD_W-1:0] ir_s;
  logic [WORD_W-1:0] imm_r;
  logic [WORD_W-1:0] imm_s;
  logic [WORD_W-1:0] din_r;
  logic [WORD_W-1:0] din_s;
  logic              run_r;
  logic              run_s;
  logic              halted_r;
  logic              halted_s;
  logic              pc_en_s;
  logic [ADDR_W-1:0] pc_s;

  // The PC only ever steps forward; the load path is unused here.
  counter_N_bits #(.N(ADDR_W)) u_pc (
    .clk  (Clock),
    .rst  (Reset),
    .en   (pc_en_s),
    .load (1'b0),
    .d    ({ADDR_W{1'b0}}),
    .q    (pc_s)
  );

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  logic step_q_r;
  logic step_rise_s;

  // Previous Step sample for rising-edge detection.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_q_r <= 1'b0;
    end else begin
      step_q_r <= bus.Step;
    end
  end

  assign step_rise_s = bus.Step & ~step_q_r;
`endif

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_s  = state_r;
    ir_s     = ir_r;
    imm_s    = imm_r;
    pc_en_s  = 1'b0;
    din_s    = din_r;
    run_s    = 1'b0;
    halted_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          state_s = FETCH_I;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH_I: begin
        state_s = LATCH_I;
      end
      LATCH_I: begin
        ir_s = bus.ROM_q;
        if (bus.ROM_q == HALT_WORD) begin
          state_s = HALTED;
        end else if (opcode_match(bus.ROM_q, OP_MVI)) begin
          pc_en_s = 1'b1;
          state_s = FETCH_M;
        end else begin
          pc_en_s = 1'b1;
          state_s = AFTER_LATCH;
        end
      end
      FETCH_M: begin
        state_s = LATCH_M;
      end
      LATCH_M: begin
        imm_s   = bus.ROM_q;
        pc_en_s = 1'b1;
        state_s = AFTER_LATCH;
      end
      ISSUE: begin
        state_s = EXEC;
      end
      EXEC: begin
        if (bus.Done) begin
          state_s = FETCH_I;
        end else begin
          state_s = EXEC;
        end
      end
      HALTED: begin
        state_s = HALTED;
      end
      ARMED: begin
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        if (step_rise_s) begin
          state_s = ISSUE;
        end else begin
          state_s = ARMED;
        end
`else
        state_s = IDLE;
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered.
    // During EXEC an mvi presents its immediate; everywhere else DIN=IR.
    if ((state_s == EXEC) && opcode_match(ir_s, OP_MVI)) begin
      din_s = imm_s;
    end else begin
      din_s = ir_s;
    end
    run_s    = (state_s == ISSUE);
    halted_s = (state_s == HALTED);
  end

  // State, instruction/immediate latches and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= IDLE;
      ir_r     <= {WORD_W{1'b0}};
      imm_r    <= {WORD_W{1'b0}};
      din_r    <= {WORD_W{1'b0}};
      run_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      ir_r     <= ir_s;
      imm_r    <= imm_s;
      din_r    <= din_s;
      run_r    <= run_s;
      halted_r <= halted_s;
    end
  end

  assign bus.ROM_addr = pc_s;
  assign bus.PC       = pc_s;
  assign bus.DIN      = din_r;
  assign bus.Run      = run_r;
  assign bus.Halted   = halted_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. A transaction-level model predicts,
// from the ROM contents and the cycle in which Start/Done is accepted, the
// cycle of each Run pulse, the words on DIN and the PC; a negedge monitor
// compares the DUT against it every cycle. Directed programs pin the model
// with literal latencies and values, then random programs with random Done
// noise and random EXEC lengths follow. Handles FETCH_SEQUENCER_SINGLE_STEP_EN.
module tb_fetch_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_HALT  = 3;
  localparam int M_ARM   = 4;

  logic       clk;
  logic       rst;
  logic [8:0] mem [0:31];
  logic [8:0] rom_q;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  // model state
  int         m_mode = M_IDLE;
  int         m_pc = 0;
  int         t_issue = 0;
  int         t_halt = 0;
  logic [8:0] e_issue = 9'h000;
  logic [8:0] e_exec = 9'h000;
  logic       stp_prev = 1'b0;

  fetch_sequencer_if #(.ADDR_W(5)) bus ();

  fetch_sequencer #(.ADDR_W(5)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROM
  always @(posedge clk) rom_q <= mem[bus.ROM_addr];
  assign bus.ROM_q = rom_q;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  initial begin
    bus.Step = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) bus.Step = ~bus.Step;
    end
  end
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accepting Start/Done in cycle t: FETCH_I t+1, LATCH_I t+2, then issue
  // at t+3 (plain) or t+5 (mvi, two more cycles for the immediate).
  task automatic schedule(input int t);
    logic [8:0] w;
    logic       mvi;
    w = mem[m_pc];
    if (w == 9'h1FF) begin
      m_mode = M_HALT;
      t_halt = t + 3;
    end else begin
      mvi     = (w[8:6] == 3'b001);
      e_issue = w;
      e_exec  = mvi ? mem[(m_pc + 1) % 32] : w;
      m_pc    = (m_pc + (mvi ? 2 : 1)) % 32;
      t_issue = t + (mvi ? 5 : 3);
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
      m_mode  = M_ARM;
`else
      m_mode  = M_FETCH;
`endif
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_run", 16'(bus.Run), 16'd0);
      chk("reset_din", 16'(bus.DIN), 16'd0);
      chk("reset_pc", 16'(bus.PC), 16'd0);
      chk("reset_halted", 16'(bus.Halted), 16'd0);
      m_mode   = M_IDLE;
      m_pc     = 0;
      stp_prev = 1'b0;
    end else begin
      chk("run", 16'(bus.Run), 16'((m_mode == M_FETCH) && (cyc == t_issue)));
      chk("halted", 16'(bus.Halted), 16'((m_mode == M_HALT) && (cyc >= t_halt)));
      case (m_mode)
        M_IDLE: begin
          chk("idle_din", 16'(bus.DIN), 16'd0);
          chk("idle_pc", 16'(bus.PC), 16'd0);
          if (bus.Start) schedule(cyc);
        end
        M_FETCH: begin
          if (cyc == t_issue) begin
            chk("issue_din", 16'(bus.DIN), 16'(e_issue));
            chk("issue_pc", 16'(bus.PC), 16'(m_pc));
            m_mode = M_EXEC;
          end
        end
        M_EXEC: begin
          chk("exec_din", 16'(bus.DIN), 16'(e_exec));
          chk("exec_addr", 16'(bus.ROM_addr), 16'(m_pc));
          if (bus.Done) schedule(cyc);
        end
        M_HALT: begin
          if (cyc >= t_halt) begin
            chk("halt_din", 16'(bus.DIN), 16'h1FF);
            chk("halt_pc", 16'(bus.PC), 16'(m_pc));
          end
        end
        M_ARM: begin
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
          if (cyc >= t_issue) begin
            chk("armed_din", 16'(bus.DIN), 16'(e_issue));
            if (bus.Step && !stp_prev) begin
              t_issue = cyc + 1;
              m_mode  = M_FETCH;
            end
          end
`endif
        end
        default: ;
      endcase
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
      stp_prev = bus.Step;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Done = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) mem[i] = 9'h1FF;
  endtask

  task automatic release_rst();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_seq(output int s);
    tick();
    bus.Start = 1'b1;
    s = cyc;
    tick();
    bus.Start = 1'b0;
  endtask

  // Returns the cycle of the Run pulse, -2 on halt, -1 on timeout.
  task automatic wait_run(input bit noisy, output int rc);
    rc = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.Done = noisy ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      if (bus.Run) begin
        rc = cyc;
        break;
      end
      if (bus.Halted) begin
        rc = -2;
        break;
      end
    end
    if (rc == -1) begin
      tests++;
      fails++;
      $display("FAIL wait_run: no Run or Halted within 400 cycles (cycle %0d)", cyc);
    end
  endtask

  // Hold Done low for 'hold' EXEC cycles, then pulse it; d = Done cycle.
  task automatic do_exec(input int hold, output int d);
    for (int i = 0; i < hold; i++) begin
      tick();
      bus.Done = 1'b0;
    end
    tick();
    bus.Done = 1'b1;
    d = cyc;
  endtask

  function automatic logic [8:0] rand_word();
    logic [8:0] w;
    int k;
    k = $urandom_range(0, 15);
    w = 9'($urandom_range(0, 510));
    if (k == 0) w = 9'h1FF;
    else if (k < 5) w[8:6] = 3'b001;
    return w;
  endfunction

  initial begin
    int r, r2, s, d;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Done = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 9'h1FF;

    // plain, plain, halt; long EXEC wait
    mem[0] = 9'h080;
    mem[1] = 9'h0C3;
    mem[2] = 9'h1FF;
    release_rst();
    start_seq(s);
    wait_run(1'b0, r);
`ifndef FETCH_SEQUENCER_SINGLE_STEP_EN
    chk("start_to_run_plain", 16'(r - s), 16'd3);
`endif
    chk("a_din0", 16'(bus.DIN), 16'h080);
    do_exec(20, d);
    wait_run(1'b0, r2);
`ifndef FETCH_SEQUENCER_SINGLE_STEP_EN
    chk("done_to_run_plain", 16'(r2 - d), 16'd3);
`endif
    chk("a_din1", 16'(bus.DIN), 16'h0C3);
    do_exec(2, d);
    wait_run(1'b0, r2);
    chk("a_halt_seen", 16'(r2 == -2), 16'd1);
    chk("a_halt_pc", 16'(bus.PC), 16'd2);
    chk("a_halt_din", 16'(bus.DIN), 16'h1FF);
    repeat (6) tick();

    // mvi R0, #5 then halt
    do_reset();
    mem[0] = 9'h040;
    mem[1] = 9'h005;
    mem[2] = 9'h1FF;
    release_rst();
    start_seq(s);
    wait_run(1'b0, r);
`ifndef FETCH_SEQUENCER_SINGLE_STEP_EN
    chk("start_to_run_mvi", 16'(r - s), 16'd5);
`endif
    chk("b_issue_din", 16'(bus.DIN), 16'h040);
    tick();
    @(negedge clk);
    chk("b_exec_imm", 16'(bus.DIN), 16'h005);
    chk("b_exec_pc", 16'(bus.PC), 16'd2);
    do_exec(3, d);
    wait_run(1'b0, r2);
    chk("b_halt_seen", 16'(r2 == -2), 16'd1);
    chk("b_halt_pc", 16'(bus.PC), 16'd2);

    // 31 words then an mvi at address 31 whose immediate wraps to address 0
    do_reset();
    mem[0] = 9'h0AA;
    for (int i = 1; i < 31; i++) mem[i] = 9'h080;
    mem[31] = 9'h041;
    release_rst();
    start_seq(s);
    for (int i = 0; i < 31; i++) begin
      wait_run(1'b1, r);
      do_exec($urandom_range(0, 2), d);
    end
    wait_run(1'b1, r);
    chk("c_issue_din", 16'(bus.DIN), 16'h041);
    tick();
    bus.Done = 1'b0;
    @(negedge clk);
    chk("c_wrap_imm", 16'(bus.DIN), 16'h0AA);
    chk("c_wrap_pc", 16'(bus.PC), 16'd1);

    // reset in the middle of EXEC, then restart from address 0
    tick();
    rst = 1'b1;
    #2;
    chk("d_async_run", 16'(bus.Run), 16'd0);
    chk("d_async_din", 16'(bus.DIN), 16'd0);
    chk("d_async_pc", 16'(bus.PC), 16'd0);
    release_rst();
    start_seq(s);
    wait_run(1'b0, r);
    chk("d_restart_din", 16'(bus.DIN), 16'h0AA);

    // reset during LATCH_M (4 cycles after Start is accepted)
    do_reset();
    mem[0] = 9'h040;
    mem[1] = 9'h005;
    mem[2] = 9'h080;
    release_rst();
    start_seq(s);
    while (cyc < s + 4) tick();
    chk("e_latchm_pc", 16'(bus.PC), 16'd1);
    rst = 1'b1;
    #2;
    chk("e_async_run", 16'(bus.Run), 16'd0);
    chk("e_async_din", 16'(bus.DIN), 16'd0);
    chk("e_async_pc", 16'(bus.PC), 16'd0);
    release_rst();
    start_seq(s);
    wait_run(1'b0, r);
    chk("e_restart_din", 16'(bus.DIN), 16'h040);
    do_exec(1, d);
    wait_run(1'b1, r);
    chk("e_next_din", 16'(bus.DIN), 16'h080);

    // random programs, random EXEC lengths, Done noise outside EXEC
    for (int p = 0; p < 6; p++) begin
      do_reset();
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      release_rst();
      start_seq(s);
      for (int n = 0; n < 40; n++) begin
        wait_run(1'b1, r);
        if (r < 0) break;
        do_exec($urandom_range(0, 20), d);
      end
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
